// File: rtl/bench_host_pkg.sv
// Shared constants and state encoding for the SPC700 bench host controller.
// Opcodes, response codes and the controller FSM states live here.
package bench_host_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 16;

    localparam logic [BYTE_W-1:0] OP_WRITE = 8'h01;
    localparam logic [BYTE_W-1:0] OP_READ  = 8'h02;
    localparam logic [BYTE_W-1:0] OP_RUN   = 8'h03;

    localparam logic [BYTE_W-1:0] RESP_ACK     = 8'h01;
    localparam logic [BYTE_W-1:0] RESP_HALT    = 8'h00;
    localparam logic [BYTE_W-1:0] RESP_TIMEOUT = 8'h01;
    localparam logic [BYTE_W-1:0] RESP_ERR     = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_WRITE_PULSE,
        ST_READ_WAIT,
        ST_RUN,
        ST_RESP
    } state_t;

    // States in which the command stream may transfer a byte.
    function automatic logic accepts_cmd(state_t s);
        return (s == ST_IDLE) || (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/bench_run_timer.sv
// Run-cycle counter for the RUN command: counts enabled cycles, flags the
// last permitted cycle, and masks the halt input during the first cycle.
module bench_run_timer
    import bench_host_pkg::*;
#(
    parameter int unsigned RUN_TIMEOUT   = 1048576,
    parameter int unsigned TIMEOUT_WIDTH = 21
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic halted,
    output logic halt_seen_c,
    output logic timeout_c
);

    logic [TIMEOUT_WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + TIMEOUT_WIDTH'(1);
        end
    end

    // Cycle with count N-1 is the last one the CPU may be enabled.
    assign timeout_c   = enable && (count_q == TIMEOUT_WIDTH'(RUN_TIMEOUT - 1));
    assign halt_seen_c = enable && halted && (count_q != '0);

endmodule

// File: rtl/bench_host_controller.sv
// Byte-stream command decoder driving the SPC700 bench RAM port and CPU enable.
// One command in flight; each command returns exactly one response byte.
module bench_host_controller
    import bench_host_pkg::*;
#(
    parameter int unsigned RUN_TIMEOUT   = 1048576,
    parameter int unsigned TIMEOUT_WIDTH = 21
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_cmd_data,
    input  logic              in_cmd_valid,
    output logic              out_cmd_ready,
    output logic [BYTE_W-1:0] out_resp_data,
    output logic              out_resp_valid,
    input  logic              in_resp_ready,
    output logic              out_cpu_enable,
    output logic [ADDR_W-1:0] out_ram_address,
    output logic [BYTE_W-1:0] out_ram_write,
    output logic              out_ram_write_enable,
    input  logic [BYTE_W-1:0] in_ram_read,
    input  logic              in_halted,
    output logic              out_busy
);

    state_t            state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;
    logic [BYTE_W-1:0] resp_q, resp_d;

    logic cmd_ready_q, resp_valid_q, cpu_enable_q, write_enable_q, busy_q;
    logic cmd_fire_c, halt_seen_c, timeout_c;

    assign cmd_fire_c = in_cmd_valid && cmd_ready_q;

    bench_run_timer #(
        .RUN_TIMEOUT   (RUN_TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_run_timer (
        .clock       (clock),
        .reset       (reset),
        .clear       (state_q != ST_RUN),
        .enable      (state_q == ST_RUN),
        .halted      (in_halted),
        .halt_seen_c (halt_seen_c),
        .timeout_c   (timeout_c)
    );

    // State and datapath registers; outputs are registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            is_write_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            resp_q         <= '0;
            cmd_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            cpu_enable_q   <= 1'b0;
            write_enable_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_write_q     <= is_write_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            resp_q         <= resp_d;
            cmd_ready_q    <= accepts_cmd(state_d);
            resp_valid_q   <= (state_d == ST_RESP);
            cpu_enable_q   <= (state_d == ST_RUN);
            write_enable_q <= (state_d == ST_WRITE_PULSE);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_c) begin
                    case (in_cmd_data)
                        OP_WRITE: begin
                            is_write_d = 1'b1;
                            state_d    = ST_ADDR_HI;
                        end
                        OP_READ: begin
                            is_write_d = 1'b0;
                            state_d    = ST_ADDR_HI;
                        end
                        OP_RUN: state_d = ST_RUN;
                        default: begin
                            resp_d  = RESP_ERR;
                            state_d = ST_RESP;
                        end
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (cmd_fire_c) begin
                    addr_d  = {in_cmd_data, addr_q[7:0]};
                    state_d = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (cmd_fire_c) begin
                    addr_d  = {addr_q[15:8], in_cmd_data};
                    state_d = is_write_q ? ST_DATA : ST_READ_WAIT;
                end
            end
            ST_DATA: begin
                if (cmd_fire_c) begin
                    wdata_d = in_cmd_data;
                    state_d = ST_WRITE_PULSE;
                end
            end
            ST_WRITE_PULSE: begin
                resp_d  = RESP_ACK;
                state_d = ST_RESP;
            end
            // RAM output settled on the falling edge; capture it now.
            ST_READ_WAIT: begin
                resp_d  = in_ram_read;
                state_d = ST_RESP;
            end
            ST_RUN: begin
                if (halt_seen_c) begin
                    resp_d  = RESP_HALT;
                    state_d = ST_RESP;
                end else if (timeout_c) begin
                    resp_d  = RESP_TIMEOUT;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (in_resp_ready && resp_valid_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_cmd_ready        = cmd_ready_q;
    assign out_resp_valid       = resp_valid_q;
    assign out_resp_data        = resp_q;
    assign out_cpu_enable       = cpu_enable_q;
    assign out_ram_address      = addr_q;
    assign out_ram_write        = wdata_q;
    assign out_ram_write_enable = write_enable_q;
    assign out_busy             = busy_q;

endmodule
